// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit:
// mdop codes, default busy lengths and controller state type.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } mdop_e;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W           = 16;

  function automatic logic is_md_start(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage MD bus: forwarded operands and opcode in, HI/LO/busy/mdout back.
interface e_mdu_if;
  logic        req;
  logic        start;
  logic [3:0]  mdop;
  logic [31:0] rs_e;
  logic [31:0] rt_e;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdout_e;

  modport master (
    output req, start, mdop, rs_e, rt_e,
    input  busy, hi, lo, mdout_e
  );

  modport slave (
    input  req, start, mdop, rs_e, rt_e,
    output busy, hi, lo, mdout_e
  );
endinterface

// File: rtl/e_mdu_counter.sv
// Loadable down-counter for the MD busy period; done flags the 1->0 edge.
module mdu_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide controller: owns HI/LO, sequences
// multi-cycle mult/div with a registered busy, serves mthi/mtlo/mfhi/mflo.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic    clk,
  input logic    reset,
  e_mdu_if.slave bus
);

  mdu_state_e  state;
  logic        busy_q;
  logic [31:0] hi_q, lo_q, p_hi, p_lo;
  logic        p_dz;
  logic        launch, cnt_done;
  logic [CNT_W-1:0] load_val;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, q_u, r_u;
  logic [31:0] res_hi, res_lo;
  logic        res_dz;

  assign launch   = (state == S_IDLE) && !bus.req && bus.start && is_md_start(bus.mdop);
  assign load_val = ((bus.mdop == MD_DIV) || (bus.mdop == MD_DIVU)) ? CNT_W'(DIV_CYCLES)
                                                                     : CNT_W'(MULT_CYCLES);

  mdu_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (launch),
    .load_val (load_val),
    .done     (cnt_done)
  );

  // Signed divide via magnitudes; 0x80000000/-1 wraps back to 0x80000000.
  always_comb begin
    prod_s = {{32{bus.rs_e[31]}}, bus.rs_e} * {{32{bus.rt_e[31]}}, bus.rt_e};
    prod_u = {32'b0, bus.rs_e} * {32'b0, bus.rt_e};
    a_mag  = bus.rs_e[31] ? (32'd0 - bus.rs_e) : bus.rs_e;
    b_mag  = bus.rt_e[31] ? (32'd0 - bus.rt_e) : bus.rt_e;
    b_safe = (bus.rt_e == '0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    q_u    = bus.rs_e / ((bus.rt_e == '0) ? 32'd1 : bus.rt_e);
    r_u    = bus.rs_e % ((bus.rt_e == '0) ? 32'd1 : bus.rt_e);
    res_dz = 1'b0;
    res_hi = '0;
    res_lo = '0;
    case (bus.mdop)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        res_dz = (bus.rt_e == '0);
        res_lo = (bus.rs_e[31] ^ bus.rt_e[31]) ? (32'd0 - q_mag) : q_mag;
        res_hi = bus.rs_e[31] ? (32'd0 - r_mag) : r_mag;
      end
      MD_DIVU: begin
        res_dz = (bus.rt_e == '0);
        res_lo = q_u;
        res_hi = r_u;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      p_dz   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) begin
            p_hi   <= res_hi;
            p_lo   <= res_lo;
            p_dz   <= res_dz;
            state  <= S_RUN;
            busy_q <= 1'b1;
          end else if (!bus.req && (bus.mdop == MD_MTHI)) begin
            hi_q <= bus.rs_e;
          end else if (!bus.req && (bus.mdop == MD_MTLO)) begin
            lo_q <= bus.rs_e;
          end
        end
        S_RUN: begin
          if (cnt_done) begin
            if (!p_dz) begin
              hi_q <= p_hi;
              lo_q <= p_lo;
            end
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mdout_e = '0;
    if (bus.mdop == MD_MFHI)      bus.mdout_e = hi_q;
    else if (bus.mdop == MD_MFLO) bus.mdout_e = lo_q;
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed table, corner sequences and
// randomized ops against an arithmetic HI/LO model.
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  e_mdu_if mif();

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi, m_lo;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference semantics in plain 64-bit arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      MD_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      MD_MULTU: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
      MD_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; m_hi = r[31:0]; m_lo = q[31:0]; end
      MD_DIVU:  if (b != 0) begin up = ua / ub; m_lo = up[31:0]; up = ua % ub; m_hi = up[31:0]; end
      MD_MTHI:  m_hi = a;
      MD_MTLO:  m_lo = a;
      default: ;
    endcase
  endtask

  task automatic idle_inputs();
    mif.req = 1'b0; mif.start = 1'b0; mif.mdop = MD_NONE;
  endtask

  // disturb: 0 none, 1 req in cycle 3, 2 start/MTHI while running, 3 MFHI while running
  task automatic issue_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int disturb, output int cycles);
    logic [31:0] old_hi;
    bit ended;
    old_hi = mif.hi;
    @(negedge clk);
    mif.start = 1'b1; mif.mdop = op; mif.rs_e = a; mif.rt_e = b;
    @(negedge clk);
    idle_inputs();
    cycles = 0;
    ended  = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      if (!mif.busy) begin ended = 1'b1; break; end
      cycles++;
      if (disturb == 1) mif.req = (k == 3);
      if (disturb == 2) begin
        case (k)
          2: begin mif.start = 1'b1; mif.mdop = MD_DIV; mif.rs_e = 32'd99; mif.rt_e = 32'd3; end
          3: begin mif.start = 1'b0; mif.mdop = MD_MTHI; mif.rs_e = 32'hDEAD; end
          default: begin mif.start = 1'b0; mif.mdop = MD_NONE; end
        endcase
      end
      if (disturb == 3 && k == 2) begin
        mif.mdop = MD_MFHI;
        #1 check("mfhi_during_run", mif.mdout_e, old_hi);
        mif.mdop = MD_NONE;
      end
      @(negedge clk);
    end
    if (!ended) begin
      n_cmp++; n_err++;
      $display("FAIL busy_timeout: busy still 1 after 64 cycles, required 0");
    end
    idle_inputs();
  endtask

  task automatic mtx(input logic [3:0] op, input logic [31:0] v, input logic rq);
    @(negedge clk);
    mif.mdop = op; mif.rs_e = v; mif.req = rq;
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    int cyc;
    logic [31:0] a, b;
    logic [3:0] op;

    vecs[0] = '{MD_MULT,  32'hFFFFFFFD, 32'd4,        32'hFFFFFFFF, 32'hFFFFFFF4, MC};
    vecs[1] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vecs[2] = '{MD_DIVU,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, DC};
    vecs[3] = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MC};
    vecs[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
    vecs[5] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};
    vecs[6] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};

    idle_inputs();
    mif.rs_e = '0; mif.rt_e = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("reset_busy", {31'b0, mif.busy}, 32'd0);
    check("reset_hi", mif.hi, 32'd0);
    check("reset_lo", mif.lo, 32'd0);

    foreach (vecs[i]) begin
      issue_md(vecs[i].op, vecs[i].a, vecs[i].b, 0, cyc);
      check($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
      check($sformatf("vec%0d_hi", i), mif.hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), mif.lo, vecs[i].exp_lo);
      mif.mdop = MD_MFLO;
      #1 check($sformatf("vec%0d_mflo", i), mif.mdout_e, vecs[i].exp_lo);
      mif.mdop = MD_MFHI;
      #1 check($sformatf("vec%0d_mfhi", i), mif.mdout_e, vecs[i].exp_hi);
      mif.mdop = MD_NONE;
      m_hi = vecs[i].exp_hi; m_lo = vecs[i].exp_lo;
    end

    // Divide by zero keeps HI/LO
    mtx(MD_MTHI, 32'h11, 1'b0);
    mtx(MD_MTLO, 32'h22, 1'b0);
    check("mthi_value", mif.hi, 32'h11);
    check("mtlo_value", mif.lo, 32'h22);
    issue_md(MD_DIV, 32'd1234, 32'd0, 0, cyc);
    check("div0_cycles", cyc, DC);
    check("div0_hi", mif.hi, 32'h11);
    check("div0_lo", mif.lo, 32'h22);
    m_hi = 32'h11; m_lo = 32'h22;

    // Flush with start / MTHI, and invalid code with start
    @(negedge clk);
    mif.req = 1'b1; mif.start = 1'b1; mif.mdop = MD_MULT; mif.rs_e = 32'd3; mif.rt_e = 32'd3;
    @(negedge clk);
    idle_inputs();
    check("flush_start_busy", {31'b0, mif.busy}, 32'd0);
    @(negedge clk);
    check("flush_start_busy2", {31'b0, mif.busy}, 32'd0);
    mtx(MD_MTHI, 32'h5, 1'b1);
    check("flush_mthi_hi", mif.hi, 32'h11);
    @(negedge clk);
    mif.start = 1'b1; mif.mdop = 4'd9;
    @(negedge clk);
    idle_inputs();
    check("code9_busy", {31'b0, mif.busy}, 32'd0);

    // req during RUN does not cancel
    issue_md(MD_MULT, 32'd7, 32'hFFFFFFFA, 1, cyc);
    model(MD_MULT, 32'd7, 32'hFFFFFFFA);
    check("req_run_cycles", cyc, MC);
    check("req_run_hi", mif.hi, m_hi);
    check("req_run_lo", mif.lo, m_lo);

    // start and MTHI while RUN ignored
    issue_md(MD_MULTU, 32'h12345678, 32'h9ABCDEF0, 2, cyc);
    model(MD_MULTU, 32'h12345678, 32'h9ABCDEF0);
    check("ign_run_cycles", cyc, MC);
    check("ign_run_hi", mif.hi, m_hi);
    check("ign_run_lo", mif.lo, m_lo);
    @(negedge clk);
    check("ign_run_no_restart", {31'b0, mif.busy}, 32'd0);

    // MFHI during RUN returns old HI
    issue_md(MD_DIVU, 32'd100, 32'd7, 3, cyc);
    model(MD_DIVU, 32'd100, 32'd7);
    check("mfhi_run_hi", mif.hi, m_hi);

    // Reset mid-RUN
    @(negedge clk);
    mif.start = 1'b1; mif.mdop = MD_DIV; mif.rs_e = 32'd77; mif.rt_e = 32'd5;
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_run_busy", {31'b0, mif.busy}, 32'd0);
    check("rst_run_hi", mif.hi, 32'd0);
    check("rst_run_lo", mif.lo, 32'd0);
    m_hi = '0; m_lo = '0;
    issue_md(MD_MULT, 32'd6, 32'd9, 0, cyc);
    model(MD_MULT, 32'd6, 32'd9);
    check("rst_after_cycles", cyc, MC);
    check("rst_after_hi", mif.hi, m_hi);
    check("rst_after_lo", mif.lo, m_lo);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 6));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if (op == MD_MTHI || op == MD_MTLO) begin
        mtx(op, a, 1'b0);
      end else begin
        issue_md(op, a, b, 0, cyc);
        check($sformatf("rnd%0d_cycles", i), cyc, (op == MD_DIV || op == MD_DIVU) ? DC : MC);
      end
      model(op, a, b);
      check($sformatf("rnd%0d_hi op%0d", i, op), mif.hi, m_hi);
      check($sformatf("rnd%0d_lo op%0d", i, op), mif.lo, m_lo);
      mif.mdop = 4'($urandom_range(0, 15));
      #1 check($sformatf("rnd%0d_mdout op%0d", i, mif.mdop), mif.mdout_e,
               (mif.mdop == 4'd7) ? m_hi : (mif.mdop == 4'd8) ? m_lo : 32'd0);
      mif.mdop = MD_NONE;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
